// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: walks one LED frame through mapper, pixel RAM and serializer handshake, then latches
module led_frame_scheduler #(
  parameter int LED_NUM    = 64,
  parameter int RST_CYCLES = 2500,
  parameter int CNT_W      = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  output logic [5:0]  idx_out,
  output logic        idx_en_out,
  input  logic [5:0]  addr_in,
  output logic        ram_rd_en_out,
  output logic [5:0]  ram_rd_addr_out,
  input  logic [23:0] ram_data_in,
  output logic [23:0] pix_data_out,
  output logic        pix_valid_out,
  input  logic        pix_ready_in,
  output logic        latch_out,
  output logic        busy_out,
  output logic        done_out
);
  typedef enum logic [6:0] {
    IDLE  = 7'b0000001,
    FETCH = 7'b0000010,
    ADDR  = 7'b0000100,
    DATA  = 7'b0001000,
    SEND  = 7'b0010000,
    LATCH = 7'b0100000,
    DONE  = 7'b1000000
  } state_t;
  state_t state, state_nx;
  logic [5:0] cnt;
  logic [CNT_W-1:0] lat_cnt;
  logic last_led, last_lat;
  assign last_led = cnt == 6'(LED_NUM - 1);
  assign last_lat = lat_cnt == CNT_W'(RST_CYCLES - 1);
  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start_in ? FETCH : IDLE;
      FETCH:   state_nx = ADDR;
      ADDR:    state_nx = DATA;
      DATA:    state_nx = SEND;
      SEND:    state_nx = !pix_ready_in ? SEND : last_led ? LATCH : FETCH;
      LATCH:   state_nx = last_lat ? DONE : LATCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state, LED counter, latch counter and pixel holding register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_cnt      <= '0;
      pix_data_out <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= (state == IDLE && start_in) ? '0 : (state == SEND && pix_ready_in && !last_led) ? cnt + 6'd1 : cnt;
      lat_cnt <= state == LATCH ? lat_cnt + CNT_W'(1) : '0;
      if (state == DATA) pix_data_out <= ram_data_in;
    end
  end
  assign idx_out         = cnt;
  assign idx_en_out      = state == FETCH;
  assign ram_rd_en_out   = state == ADDR;
  assign ram_rd_addr_out = ram_rd_en_out ? addr_in : '0;
  assign pix_valid_out   = state == SEND;
  assign latch_out       = state == LATCH;
  assign done_out        = state == DONE;
  assign busy_out        = state != IDLE;
endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb_led_frame_scheduler: randomized frames checked every cycle against a frame-progress model
module tb_led_frame_scheduler;
  localparam int N = 64;
  localparam int R = 2500;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, start = 0, ready = 1;
  logic [5:0] addr_in = '0;
  logic [23:0] ram_data = '0;
  logic [5:0] idx_out, ram_rd_addr_out;
  logic idx_en_out, ram_rd_en_out, pix_valid_out, latch_out, busy_out, done_out;
  logic [23:0] pix_data_out;
  logic start_b = 0, start_c = 0;
  logic [5:0] addr_b = '0, idx_b, rd_addr_b, idx_c, rd_addr_c;
  logic idx_en_b, rd_en_b, valid_b, latch_b, busy_b, done_b;
  logic idx_en_c, rd_en_c, valid_c, latch_c, busy_c, done_c;
  logic [23:0] pix_b, pix_c;
  logic [23:0] ram [64];
  logic [23:0] hs_data [64];
  bit smode = 0;
  int n_chk = 0, n_fail = 0;
  led_frame_scheduler #(.LED_NUM(N), .RST_CYCLES(R), .CNT_W(16)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .idx_out(idx_out), .idx_en_out(idx_en_out),
    .addr_in(addr_in), .ram_rd_en_out(ram_rd_en_out), .ram_rd_addr_out(ram_rd_addr_out),
    .ram_data_in(ram_data), .pix_data_out(pix_data_out), .pix_valid_out(pix_valid_out),
    .pix_ready_in(ready), .latch_out(latch_out), .busy_out(busy_out), .done_out(done_out));
  led_frame_scheduler #(.LED_NUM(16), .RST_CYCLES(8), .CNT_W(16)) dut_b (
    .clk_in(clk), .rst_in(rst), .start_in(start_b), .idx_out(idx_b), .idx_en_out(idx_en_b),
    .addr_in(addr_b), .ram_rd_en_out(rd_en_b), .ram_rd_addr_out(rd_addr_b),
    .ram_data_in(24'h0), .pix_data_out(pix_b), .pix_valid_out(valid_b),
    .pix_ready_in(1'b1), .latch_out(latch_b), .busy_out(busy_b), .done_out(done_b));
  led_frame_scheduler #(.LED_NUM(1), .RST_CYCLES(1), .CNT_W(16)) dut_c (
    .clk_in(clk), .rst_in(rst), .start_in(start_c), .idx_out(idx_c), .idx_en_out(idx_en_c),
    .addr_in(6'h0), .ram_rd_en_out(rd_en_c), .ram_rd_addr_out(rd_addr_c),
    .ram_data_in(24'h0), .pix_data_out(pix_c), .pix_valid_out(valid_c),
    .pix_ready_in(1'b1), .latch_out(latch_c), .busy_out(busy_c), .done_out(done_c));
  function automatic logic [5:0] map6(input logic [5:0] i, input bit s);
    int row, col;
    row = i / 8;
    col = i % 8;
    return (s && row % 2 == 1) ? 6'(row * 8 + 7 - col) : i;
  endfunction
  function automatic bit in_led(input int p);
    return p >= 0 && p < 4 * N;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // environment: registered mappers and pixel RAM
  always @(posedge clk) begin
    addr_in  <= idx_en_out ? map6(idx_out, smode) : 6'd0;
    ram_data <= ram_rd_en_out ? ram[ram_rd_addr_out] : 24'd0;
    addr_b   <= idx_en_b ? map6(idx_b, 1'b1) : 6'd0;
  end
  // model: m_p is frame progress in cycles (-1 idle); 4 per LED, stalls freeze it, then R latch cycles, then done
  int m_p = -1;
  logic [23:0] m_pix = '0;
  logic [5:0] m_idx = '0;
  bit armed = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_p   <= -1;
      m_pix <= '0;
      m_idx <= '0;
      armed <= 1;
    end else begin
      if (m_p < 0) m_p <= start ? 0 : -1;
      else if (m_p == 4 * N + R) m_p <= -1;
      else if (in_led(m_p) && m_p % 4 == 3 && !ready) m_p <= m_p;
      else m_p <= m_p + 1;
      if (in_led(m_p) && m_p % 4 == 2) m_pix <= ram[map6(6'(m_p / 4), smode)];
      if (in_led(m_p)) m_idx <= 6'(m_p / 4);
    end
  end
  // per-cycle compare of the main DUT against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("idx_en", idx_en_out, in_led(m_p) && m_p % 4 == 0);
      chk("idx", idx_out, in_led(m_p) ? 6'(m_p / 4) : m_idx);
      chk("rd_en", ram_rd_en_out, in_led(m_p) && m_p % 4 == 1);
      if (in_led(m_p) && m_p % 4 == 1) chk("rd_addr", ram_rd_addr_out, map6(6'(m_p / 4), smode));
      chk("valid", pix_valid_out, in_led(m_p) && m_p % 4 == 3);
      chk("pix", pix_data_out, m_pix);
      chk("latch", latch_out, m_p >= 4 * N && m_p < 4 * N + R);
      chk("done", done_out, m_p == 4 * N + R);
      chk("busy", busy_out, m_p >= 0);
    end
  end
  task automatic fill_ram(input bit rnd);
    for (int i = 0; i < 64; i++) ram[i] = rnd ? 24'($urandom) : 24'(i);
  endtask
  // rmode: 0 ready high, 1 ready low 5 cycles on LED 10, 2 random; poke pulses start during LED 20 SEND and DONE
  task automatic run_frame(input int rmode, input bit poke, output int len, output int lat,
                           output int fv, output int hs, output int v10, output int fidx);
    int cyc, stall, dn;
    bit seen;
    cyc = 0; stall = 0; dn = 0; seen = 0;
    len = 0; lat = 0; fv = 0; hs = 0; v10 = 0; fidx = -1;
    ready = 1;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 9000; k++) begin
      if (idx_en_out && !seen) begin seen = 1; fidx = idx_out; end
      if (seen) cyc++;
      if (pix_valid_out && fv == 0) fv = cyc;
      if (pix_valid_out && idx_out == 6'd10) v10++;
      if (latch_out) lat++;
      start = poke && ((pix_valid_out && idx_out == 6'd20) || done_out);
      if (rmode == 1) begin
        ready = !(pix_valid_out && idx_out == 6'd10 && stall < 5);
        if (!ready) stall++;
      end else if (rmode == 2) ready = 1'($urandom_range(0, 1));
      else ready = 1;
      if (pix_valid_out && ready) begin
        if (hs < 64) hs_data[hs] = pix_data_out;
        hs++;
      end
      if (done_out) begin dn = 1; len = cyc; break; end
      @(negedge clk);
    end
    if (dn == 0) chk("frame_timeout", 0, 1);
    @(negedge clk);
    start = 0;
    ready = 1;
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int len, lat, fv, hs, v10, fidx, dn, c1, c2, cyc, vc, lc;
    int exp_b [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 15, 14, 13, 12, 11, 10, 9, 8};
    logic [5:0] q_addr [$];
    logic [5:0] q_idx [$];
    bit hit;
    fill_ram(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_out, 0);
    chk("rst_pix", pix_data_out, 0);
    chk("rst_idx", idx_out, 0);
    chk("rst_valid", pix_valid_out, 0);
    rst = 0;
    run_frame(0, 0, len, lat, fv, hs, v10, fidx);
    chk("f1_len", len, 2757);
    chk("f1_latch", lat, 2500);
    chk("f1_first_valid", fv, 4);
    chk("f1_handshakes", hs, 64);
    chk("f1_first_idx", fidx, 0);
    chk("f1_v10", v10, 1);
    for (int i = 0; i < 64; i++) chk("f1_data", hs_data[i], i);
    run_frame(1, 0, len, lat, fv, hs, v10, fidx);
    chk("f2_len", len, 2762);
    chk("f2_v10", v10, 6);
    chk("f2_handshakes", hs, 64);
    chk("f2_data10", hs_data[10], 10);
    run_frame(0, 1, len, lat, fv, hs, v10, fidx);
    chk("f3_len", len, 2757);
    chk("f3_handshakes", hs, 64);
    for (int i = 0; i < 3; i++) begin
      chk("f3_idle_busy", busy_out, 0);
      chk("f3_idle_done", done_out, 0);
      @(negedge clk);
    end
    fill_ram(1);
    smode = 1;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    hit = 0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      hit = latch_out;
      @(negedge clk);
    end
    chk("reach_latch", hit, 1);
    repeat (100) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", busy_out, 0);
    chk("abort_latch", latch_out, 0);
    chk("abort_pix", pix_data_out, 0);
    chk("abort_idx", idx_out, 0);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_out) dn++;
      @(negedge clk);
    end
    chk("abort_no_done", dn, 0);
    run_frame(2, 0, len, lat, fv, hs, v10, fidx);
    chk("restart_idx", fidx, 0);
    chk("restart_hs", hs, 64);
    for (int f = 0; f < 2; f++) begin
      fill_ram(1);
      smode = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame(2, 0, len, lat, fv, hs, v10, fidx);
      chk("rand_hs", hs, 64);
      chk("rand_latch", lat, 2500);
    end
    start = 1;
    dn = 0; c1 = 0; c2 = 0;
    for (int k = 1; k < 7000 && dn < 2; k++) begin
      if (done_out) begin dn++; if (dn == 1) c1 = k; end
      if (idx_en_out && idx_out == 6'd0 && dn == 1 && c2 == 0) c2 = k;
      @(negedge clk);
    end
    start = 0;
    chk("b2b_dones", dn, 2);
    chk("b2b_gap", c2 - c1, 2);
    @(negedge clk);
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    hit = 0;
    for (int k = 0; k < 400 && !hit; k++) begin
      if (rd_en_b) q_addr.push_back(rd_addr_b);
      if (idx_en_b) q_idx.push_back(idx_b);
      hit = done_b;
      @(negedge clk);
    end
    chk("b_done", hit, 1);
    chk("b_addr_count", q_addr.size(), 16);
    chk("b_idx_count", q_idx.size(), 16);
    for (int i = 0; i < 16 && i < q_addr.size() && i < q_idx.size(); i++) begin
      chk("b_addr", q_addr[i], exp_b[i]);
      chk("b_idx", q_idx[i], i);
    end
    start_c = 1;
    @(negedge clk);
    start_c = 0;
    cyc = 0; vc = 0; lc = 0; len = 0;
    for (int k = 0; k < 50 && len == 0; k++) begin
      if (idx_en_c || cyc > 0) cyc++;
      if (valid_c) vc = cyc;
      if (latch_c) lc = cyc;
      if (done_c) len = cyc;
      @(negedge clk);
    end
    chk("c_len", len, 6);
    chk("c_valid_cycle", vc, 4);
    chk("c_latch_cycle", lc, 5);
    chk("c_idle_after", busy_c, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
